// File: rtl/alu_sched_pkg.sv
// alu_sched shared types and constants.
// Used by the scheduler, its arbiter and the bench.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;
  localparam int SEL_W  = 4;

endpackage

// File: rtl/alu_sched_if.sv
// Requester, ALU and response bus of alu_sched.
// slave = scheduler side, master = sources/ALU/consumer side.
interface alu_sched_if #(
  parameter int NBITS = 16,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*NBITS-1:0] req_a;
  logic [NREQ*NBITS-1:0] req_b;
  logic [NREQ*4-1:0]     req_sel;

  logic [NBITS-1:0]      alu_a;
  logic [NBITS-1:0]      alu_b;
  logic [3:0]            alu_sel;
  logic [NBITS-1:0]      alu_out;
  logic [3:0]            alu_flags;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [NBITS-1:0]      rsp_out;
  logic [3:0]            rsp_flags;

  modport slave (
    input  req_valid, req_a, req_b, req_sel,
    output req_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_out, alu_flags,
    output rsp_valid, rsp_id, rsp_out, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a, req_b, req_sel,
    input  req_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_out, alu_flags,
    input  rsp_valid, rsp_id, rsp_out, rsp_flags,
    output rsp_ready
  );

endinterface

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first req at/after ptr.
// Search wraps NREQ-1 -> 0; gnt is one-hot or zero.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  int   idx;
  logic found;

  // scan from ptr, wrapping, and keep the first hit
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one external ALU between NREQ requesters, one op at a time.
// ALU_SCHED_FIXED_PRIO_EN: fixed priority (lowest index), else round-robin.
module alu_sched #(
  parameter int NBITS = 16,
  parameter int NREQ  = 4
) (
  input logic        clk,
  input logic        rst_n,
  alu_sched_if.slave bus
);
  import alu_sched_pkg::*;

  localparam int IDW = $clog2(NREQ);

  sched_state_t    state, state_nx;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  arb_ptr;
  logic [IDW-1:0]  ptr_nx;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            hs;

`ifdef ALU_SCHED_FIXED_PRIO_EN
  assign arb_ptr = '0;
  assign ptr_nx  = '0;
`else
  assign arb_ptr = rr_ptr;
  assign ptr_nx  = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (bus.req_valid),
    .ptr    (arb_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign hs = (state == IDLE) && (|gnt);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (|gnt) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // grant only while idle; response valid while in RESP
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    unique case (state)
      IDLE:    bus.req_ready = gnt;
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // operand latch on handshake, result capture after EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_sel   <= '0;
      bus.rsp_id    <= '0;
      bus.rsp_out   <= '0;
      bus.rsp_flags <= '0;
    end else if (hs) begin
      bus.alu_a   <= bus.req_a[int'(gnt_id)*NBITS +: NBITS];
      bus.alu_b   <= bus.req_b[int'(gnt_id)*NBITS +: NBITS];
      bus.alu_sel <= bus.req_sel[int'(gnt_id)*SEL_W +: SEL_W];
      bus.rsp_id  <= gnt_id;
      rr_ptr      <= ptr_nx;
    end else if (state == EXEC) begin
      bus.rsp_out   <= bus.alu_out;
      bus.rsp_flags <= bus.alu_flags;
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with an inline ALU model.
// Model: sel 0 = ADD, 1 = SUB, 2 = AND, 3 = OR, else XOR.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int NBITS = 16;
  localparam int NREQ  = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_sched_if #(.NBITS(NBITS), .NREQ(NREQ)) bus ();

  alu_sched #(.NBITS(NBITS), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NBITS:0] sum;

  // reference ALU on the alu_* bus
  always_comb begin
    sum           = '0;
    bus.alu_out   = '0;
    bus.alu_flags = '0;
    case (bus.alu_sel)
      4'd0: sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      4'd1: sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      4'd2: sum = {1'b0, bus.alu_a & bus.alu_b};
      4'd3: sum = {1'b0, bus.alu_a | bus.alu_b};
      default: sum = {1'b0, bus.alu_a ^ bus.alu_b};
    endcase
    bus.alu_out = sum[NBITS-1:0];
    bus.alu_flags[FLAG_C] = sum[NBITS];
    bus.alu_flags[FLAG_N] = sum[NBITS-1];
    bus.alu_flags[FLAG_Z] = (sum[NBITS-1:0] == '0);
    if (bus.alu_sel == 4'd0)
      bus.alu_flags[FLAG_V] =
        (bus.alu_a[NBITS-1] == bus.alu_b[NBITS-1]) &&
        (sum[NBITS-1] != bus.alu_a[NBITS-1]);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] s);
    bus.req_a[i*NBITS +: NBITS] = a;
    bus.req_b[i*NBITS +: NBITS] = b;
    bus.req_sel[i*4 +: 4]       = s;
  endtask

  int exp_id;

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b0;

    // 1. reset
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_alu_a", 32'(bus.alu_a), 0);
    chk("rst_alu_sel", 32'(bus.alu_sel), 0);
    chk("rst_rsp_out", 32'(bus.rsp_out), 0);
    chk("rst_rsp_flags", 32'(bus.rsp_flags), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_rr_ptr", 32'(dut.rr_ptr), 0);

    // 2. single request on slot 2: 5+3
    load(2, 16'd5, 16'd3, 4'd0);
    bus.req_valid = 4'b0100;
    #1 chk("single_grant", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    bus.req_valid = '0;
    load(2, 16'd99, 16'd99, 4'd3);
    #1;
    chk("exec_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("exec_req_ready", 32'(bus.req_ready), 0);
    chk("exec_alu_a", 32'(bus.alu_a), 5);
    chk("exec_alu_b", 32'(bus.alu_b), 3);
    @(negedge clk);
    chk("single_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("single_rsp_id", 32'(bus.rsp_id), 2);
    chk("single_rsp_out", 32'(bus.rsp_out), 8);
    chk("single_flag_z", 32'(bus.rsp_flags[FLAG_Z]), 0);

    // 4. backpressure with a pending requester
    load(0, 16'h7FFF, 16'h0001, 4'd0);
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_rsp_out", 32'(bus.rsp_out), 8);
      chk("bp_rsp_id", 32'(bus.rsp_id), 2);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1 chk("bp_next_grant", 32'(bus.req_ready), 32'h1);
    chk("bp_rsp_valid_drop", 32'(bus.rsp_valid), 0);

    // 5a. 7FFF + 1: overflow into negative
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    chk("ovf_rsp_out", 32'(bus.rsp_out), 32'h8000);
    chk("ovf_flags", 32'(bus.rsp_flags), 32'b0110);
    chk("ovf_rsp_id", 32'(bus.rsp_id), 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // 5b. FFFF + 1: carry and zero
    load(1, 16'hFFFF, 16'h0001, 4'd0);
    bus.req_valid = 4'b0010;
    #1 chk("carry_grant", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    chk("carry_rsp_out", 32'(bus.rsp_out), 0);
    chk("carry_flags", 32'(bus.rsp_flags), 32'b1001);
    chk("carry_rsp_id", 32'(bus.rsp_id), 1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // 6. reset while in EXEC
    load(3, 16'd1, 16'd1, 4'd0);
    bus.req_valid = 4'b1000;
    #1 chk("mid_grant", 32'(bus.req_ready), 32'h8);
    @(negedge clk);
    bus.req_valid = '0;
    #1 chk("mid_in_exec", 32'(dut.state), 32'(EXEC));
    rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rr_ptr", 32'(dut.rr_ptr), 0);
    chk("mid_alu_a", 32'(bus.alu_a), 0);
    repeat (2) @(negedge clk);
    chk("mid_rsp_valid_hold", 32'(bus.rsp_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3. all requesters pending, consumer always ready
    for (int i = 0; i < NREQ; i++)
      load(i, 16'(100 + i), 16'(i), 4'd0);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = k % NREQ;
`endif
      #1 chk("rr_grant", 32'(bus.req_ready), 32'(1 << exp_id));
      @(negedge clk);
      @(negedge clk);
      chk("rr_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("rr_rsp_id", 32'(bus.rsp_id), 32'(exp_id));
      chk("rr_rsp_out", 32'(bus.rsp_out), 32'(100 + 2 * exp_id));
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
